// File: rtl/axi_transmit.sv
// Serialises one BUS_WIDTH-bit packet into NUM_WORDS AXI-Stream beats, least-significant chunk first.
// The last beat is zero-padded above BUS_WIDTH, and packet_sent pulses once after the final handshake.
module axi_transmit #(
  parameter int BUS_WIDTH  = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [BUS_WIDTH-1:0]  data_to_send,
  input  logic                  send,
  output logic                  trans_rdy,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid_data,
  output logic                  last,
  input  logic                  dev_rdy,
  output logic                  packet_sent
);

  localparam int NUM_WORDS = (BUS_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int PAD_W     = NUM_WORDS * DATA_WIDTH;
  localparam int IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [PAD_W-1:0] r_buf;
  logic [IDX_W-1:0] r_idx;
  logic             r_packet_sent;
  logic             w_load;
  logic             w_advance;
  logic             w_finish;
  logic             w_last;
  logic [PAD_W-1:0] w_shifted;

  assign w_last    = (r_state == SEND) && (r_idx == IDX_W'(NUM_WORDS - 1));
  // Buffer is wider than the packet; the padding bits were loaded as zero.
  assign w_shifted = r_buf >> (int'(r_idx) * DATA_WIDTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_advance    = 1'b0;
    w_finish     = 1'b0;
    trans_rdy    = 1'b0;
    valid_data   = 1'b0;
    last         = 1'b0;
    data         = '0;
    case (r_state)
      IDLE: begin
        trans_rdy = 1'b1;
        if (send) begin
          w_load       = 1'b1;
          w_next_state = SEND;
        end
      end
      SEND: begin
        valid_data = 1'b1;
        last       = w_last;
        data       = w_shifted[DATA_WIDTH-1:0];
        if (dev_rdy) begin
          if (w_last) begin
            w_finish     = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf         <= '0;
      r_idx         <= '0;
      r_packet_sent <= 1'b0;
    end else begin
      r_packet_sent <= w_finish;
      if (w_load) begin
        r_buf <= PAD_W'(data_to_send);
        r_idx <= '0;
      end else if (w_advance) begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  assign packet_sent = r_packet_sent;

endmodule

// File: tb/tb_axi_transmit.sv
// Exercises twelve BUS_WIDTH/DATA_WIDTH builds of axi_transmit against a chunk-slicing reference model.
// Each packet is reassembled from the observed beats and compared with the packet that was sent.
module tb_axi_transmit;

  localparam int NCFG = 12;

  function automatic int bw_of(int g);
    case (g % 6)
      0:       return 1;
      1:       return 2;
      2:       return 11;
      3:       return 16;
      4:       return 32;
      default: return 111;
    endcase
  endfunction

  function automatic int dw_of(int g);
    return (g < 6) ? 16 : 32;
  endfunction

  function automatic int nw_of(int g);
    return (bw_of(g) + dw_of(g) - 1) / dw_of(g);
  endfunction

  function automatic logic [255:0] mask_pkt(logic [255:0] p, int bw);
    return p & ((256'd1 << bw) - 256'd1);
  endfunction

  function automatic logic [63:0] chunk(logic [255:0] p, int bw, int dw, int k);
    logic [255:0] m;
    m = mask_pkt(p, bw) >> (k * dw);
    return m[63:0] & ((64'd1 << dw) - 64'd1);
  endfunction

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NCFG-1:0]        send_v;
  logic [NCFG-1:0]        dev_rdy_v;
  logic [255:0]           dts [NCFG];
  logic [NCFG-1:0]        trdy_v;
  logic [NCFG-1:0]        vld_v;
  logic [NCFG-1:0]        last_v;
  logic [NCFG-1:0]        ps_v;
  logic [NCFG-1:0][63:0]  dat;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    localparam int BW = bw_of(g);
    localparam int DW = dw_of(g);
    logic [DW-1:0] w_dat;
    logic          w_trdy, w_vld, w_last, w_ps;

    axi_transmit #(.BUS_WIDTH(BW), .DATA_WIDTH(DW)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .data_to_send (dts[g][BW-1:0]),
      .send         (send_v[g]),
      .trans_rdy    (w_trdy),
      .data         (w_dat),
      .valid_data   (w_vld),
      .last         (w_last),
      .dev_rdy      (dev_rdy_v[g]),
      .packet_sent  (w_ps)
    );

    assign dat[g]    = 64'(w_dat);
    assign trdy_v[g] = w_trdy;
    assign vld_v[g]  = w_vld;
    assign last_v[g] = w_last;
    assign ps_v[g]   = w_ps;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_pkt();
    logic [255:0] p;
    for (int i = 0; i < 8; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // mode: 0 dev_rdy=1, 1 toggling, 2 stalled for the first 5 beat cycles, 3 random.
  // Entered and left on a falling edge with the DUT idle.
  task automatic run_pkt(input int g, input logic [255:0] pkt, input int mode,
                         input bit intrude, output logic [255:0] reasm);
    int n, dw, bw, k, c;
    logic dr;
    n = nw_of(g); dw = dw_of(g); bw = bw_of(g); k = 0; c = 0;
    reasm = '0;
    check("idle_trans_rdy", 256'(trdy_v[g]), 256'(1));
    check("idle_valid", 256'(vld_v[g]), 256'(0));
    dts[g]       = pkt;
    send_v[g]    = 1'b1;
    dev_rdy_v[g] = 1'($urandom_range(0, 1));
    @(negedge clk);
    send_v[g] = 1'b0;
    dts[g]    = rand_pkt();
    while (k < n && c < 200) begin
      check("beat_valid", 256'(vld_v[g]), 256'(1));
      check("beat_trans_rdy", 256'(trdy_v[g]), 256'(0));
      check("beat_data", 256'(dat[g]), 256'(chunk(pkt, bw, dw, k)));
      check("beat_last", 256'(last_v[g]), 256'(k == n - 1));
      check("beat_no_sent", 256'(ps_v[g]), 256'(0));
      if (intrude && c == 1) begin
        send_v[g] = 1'b1;
        dts[g]    = ~pkt;
      end else begin
        send_v[g] = 1'b0;
      end
      case (mode)
        0:       dr = 1'b1;
        1:       dr = c[0];
        2:       dr = (c >= 5);
        default: dr = 1'($urandom_range(0, 1));
      endcase
      dev_rdy_v[g] = dr;
      if (dr) begin
        reasm = reasm | (256'(dat[g]) << (k * dw));
        k++;
      end
      c++;
      @(negedge clk);
    end
    send_v[g] = 1'b0;
    check("no_timeout", 256'(c < 200), 256'(1));
    check("packet_sent_pulse", 256'(ps_v[g]), 256'(1));
    check("done_trans_rdy", 256'(trdy_v[g]), 256'(1));
    check("done_valid", 256'(vld_v[g]), 256'(0));
    check("reassembled", reasm, mask_pkt(pkt, bw));
  endtask

  initial begin
    logic [255:0] pkt, r;
    rst       = 1'b0;
    send_v    = '0;
    dev_rdy_v = '0;
    for (int i = 0; i < NCFG; i++) dts[i] = rand_pkt();
    #1;
    for (int i = 0; i < NCFG; i++) begin
      check("rst_trans_rdy", 256'(trdy_v[i]), 256'(1));
      check("rst_valid", 256'(vld_v[i]), 256'(0));
      check("rst_last", 256'(last_v[i]), 256'(0));
      check("rst_data", 256'(dat[i]), 256'(0));
      check("rst_sent", 256'(ps_v[i]), 256'(0));
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Single-bit packet in one 32-bit beat.
    run_pkt(6, 256'd1, 0, 1'b0, r);
    check("bw1_beat", r, 256'd1);

    // 111-bit packet over seven 16-bit beats; the padding bit must come out zero.
    pkt = rand_pkt();
    pkt[111] = 1'b1;
    run_pkt(5, pkt, 0, 1'b0, r);
    check("pad_bit111", 256'(r[111]), 256'(0));

    // Sink stalled for 5 cycles on beat 0.
    run_pkt(4, rand_pkt(), 2, 1'b0, r);

    // send pulsed mid-packet with different data.
    pkt = rand_pkt();
    run_pkt(5, pkt, 0, 1'b1, r);
    @(negedge clk);
    check("intrude_stays_idle", 256'(vld_v[5]), 256'(0));

    // Reset while beat 2 of a 7-beat packet is on the bus.
    pkt = rand_pkt();
    dts[5] = pkt; send_v[5] = 1'b1; dev_rdy_v[5] = 1'b1;
    @(negedge clk);
    send_v[5] = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_beat2", 256'(dat[5]), 256'(chunk(pkt, 111, 16, 2)));
    rst = 1'b0;
    #1;
    check("midrst_trans_rdy", 256'(trdy_v[5]), 256'(1));
    check("midrst_valid", 256'(vld_v[5]), 256'(0));
    check("midrst_last", 256'(last_v[5]), 256'(0));
    check("midrst_data", 256'(dat[5]), 256'(0));
    check("midrst_sent", 256'(ps_v[5]), 256'(0));
    @(negedge clk);
    check("midrst_sent_hold", 256'(ps_v[5]), 256'(0));
    rst = 1'b1;
    run_pkt(5, rand_pkt(), 0, 1'b0, r);

    // Full width sweep.
    for (int g = 0; g < NCFG; g++) begin
      for (int p = 0; p < 20; p++) run_pkt(g, rand_pkt(), 0, 1'b0, r);
      for (int p = 0; p < 20; p++) run_pkt(g, rand_pkt(), 1, 1'b0, r);
      for (int p = 0; p < 5; p++)  run_pkt(g, rand_pkt(), 3, 1'b0, r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
